// File: rtl/rv_alu_pkg.sv
// Shared definitions for the execute-stage ALU: op codes, FSM states and op-class helpers.
package rv_alu_pkg;

  localparam int unsigned CTRL_W  = 5;
  localparam int unsigned SHAMT_W = 5;

  localparam logic [CTRL_W-1:0] ALU_ADD   = 5'd1;
  localparam logic [CTRL_W-1:0] ALU_ADDI  = 5'd2;
  localparam logic [CTRL_W-1:0] ALU_OR    = 5'd3;
  localparam logic [CTRL_W-1:0] ALU_ORI   = 5'd4;
  localparam logic [CTRL_W-1:0] ALU_XOR   = 5'd5;
  localparam logic [CTRL_W-1:0] ALU_XORI  = 5'd6;
  localparam logic [CTRL_W-1:0] ALU_AND   = 5'd7;
  localparam logic [CTRL_W-1:0] ALU_ANDI  = 5'd8;
  localparam logic [CTRL_W-1:0] ALU_SUB   = 5'd9;
  localparam logic [CTRL_W-1:0] ALU_SLT   = 5'd10;
  localparam logic [CTRL_W-1:0] ALU_SLTI  = 5'd11;
  localparam logic [CTRL_W-1:0] ALU_SLTU  = 5'd12;
  localparam logic [CTRL_W-1:0] ALU_SLTIU = 5'd13;
  localparam logic [CTRL_W-1:0] ALU_SLLI  = 5'd14;
  localparam logic [CTRL_W-1:0] ALU_SRLI  = 5'd15;
  localparam logic [CTRL_W-1:0] ALU_SRAI  = 5'd16;
  localparam logic [CTRL_W-1:0] ALU_SLL   = 5'd17;
  localparam logic [CTRL_W-1:0] ALU_SRL   = 5'd18;
  localparam logic [CTRL_W-1:0] ALU_SRA   = 5'd19;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } alu_state_e;

  function automatic logic is_shift(input logic [CTRL_W-1:0] code);
    return (code >= ALU_SLLI) && (code <= ALU_SRA);
  endfunction

  function automatic logic is_illegal(input logic [CTRL_W-1:0] code);
    return (code == '0) || (code > ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// Request/response bundle between issue logic, the ALU and writeback.
interface alu_exec_unit_if import rv_alu_pkg::*; #(
  parameter int unsigned XLEN = 32
);

  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] alu_ctrl;
  logic [XLEN-1:0]   op_a;
  logic [XLEN-1:0]   op_b;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   result;
  logic              zero;
  logic              illegal;
  logic              busy;

  modport master (
    output in_valid, alu_ctrl, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, zero, illegal, busy
  );

  modport slave (
    input  in_valid, alu_ctrl, op_a, op_b, out_ready,
    output in_ready, out_valid, result, zero, illegal, busy
  );

endinterface

// File: rtl/alu_shift_engine.sv
// Iterative shifter: loads on start, moves up to SHIFT_STEP bits per cycle, flags the final step.
module alu_shift_engine import rv_alu_pkg::*; #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned SHIFT_STEP = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush_i,
  input  logic               start_i,
  input  logic [XLEN-1:0]    data_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  input  logic               left_i,
  input  logic               arith_i,
  output logic               done_c,
  output logic [XLEN-1:0]    result_c
);

  localparam int unsigned CNT_W = 6;

  logic [XLEN-1:0]  shreg_q, shreg_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] step_c;
  logic             left_q, left_d;
  logic             arith_q, arith_d;
  logic             active_q, active_d;

  // Arithmetic right shifts keep replicating the original sign bit, which never moves.
  always_comb begin
    step_c = (rem_q < CNT_W'(SHIFT_STEP)) ? rem_q : CNT_W'(SHIFT_STEP);
    if (left_q) begin
      result_c = shreg_q << step_c;
    end else if (arith_q) begin
      result_c = XLEN'($signed(shreg_q) >>> step_c);
    end else begin
      result_c = shreg_q >> step_c;
    end
    done_c = active_q && (rem_q == step_c);
  end

  always_comb begin
    shreg_d  = shreg_q;
    rem_d    = rem_q;
    left_d   = left_q;
    arith_d  = arith_q;
    active_d = active_q;
    if (flush_i) begin
      rem_d    = '0;
      active_d = 1'b0;
    end else if (start_i) begin
      shreg_d  = data_i;
      rem_d    = CNT_W'(shamt_i);
      left_d   = left_i;
      arith_d  = arith_i;
      active_d = 1'b1;
    end else if (active_q) begin
      shreg_d = result_c;
      rem_d   = rem_q - step_c;
      if (done_c) begin
        active_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q  <= '0;
      rem_q    <= '0;
      left_q   <= 1'b0;
      arith_q  <= 1'b0;
      active_q <= 1'b0;
    end else begin
      shreg_q  <= shreg_d;
      rem_q    <= rem_d;
      left_q   <= left_d;
      arith_q  <= arith_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle integer ops, iterative shifts, registered result toward writeback.
module alu_exec_unit import rv_alu_pkg::*; #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned SHIFT_STEP = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  alu_exec_unit_if.slave bus
);

  alu_state_e      state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            zero_q, zero_d;
  logic            illegal_q, illegal_d;
  logic            valid_q, valid_d;

  logic            in_ready_c;
  logic            accept_c;
  logic            load_c;
  logic            shift_go_c;
  logic            left_c;
  logic            arith_c;
  logic            eng_start_c;
  logic            eng_done_c;
  logic [XLEN-1:0] eng_res_c;
  logic [XLEN-1:0] alu_res_c;

  assign in_ready_c = (state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.out_ready);
  assign accept_c   = bus.in_valid && in_ready_c && !flush;
  assign shift_go_c = is_shift(bus.alu_ctrl) && (bus.op_b[SHAMT_W-1:0] != '0);
  assign left_c     = (bus.alu_ctrl == ALU_SLL) || (bus.alu_ctrl == ALU_SLLI);
  assign arith_c    = (bus.alu_ctrl == ALU_SRA) || (bus.alu_ctrl == ALU_SRAI);

  // Single-cycle datapath; a zero-distance shift passes op_a through, illegal codes give 0.
  always_comb begin
    alu_res_c = '0;
    case (bus.alu_ctrl)
      ALU_ADD,  ALU_ADDI:  alu_res_c = bus.op_a + bus.op_b;
      ALU_OR,   ALU_ORI:   alu_res_c = bus.op_a | bus.op_b;
      ALU_XOR,  ALU_XORI:  alu_res_c = bus.op_a ^ bus.op_b;
      ALU_AND,  ALU_ANDI:  alu_res_c = bus.op_a & bus.op_b;
      ALU_SUB:             alu_res_c = bus.op_a - bus.op_b;
      ALU_SLT,  ALU_SLTI:  alu_res_c = XLEN'($signed(bus.op_a) < $signed(bus.op_b));
      ALU_SLTU, ALU_SLTIU: alu_res_c = XLEN'(bus.op_a < bus.op_b);
      ALU_SLLI, ALU_SRLI, ALU_SRAI,
      ALU_SLL,  ALU_SRL,  ALU_SRA:   alu_res_c = bus.op_a;
      default:             alu_res_c = '0;
    endcase
  end

  alu_shift_engine #(
    .XLEN       (XLEN),
    .SHIFT_STEP (SHIFT_STEP)
  ) u_shift (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush_i  (flush),
    .start_i  (eng_start_c),
    .data_i   (bus.op_a),
    .shamt_i  (bus.op_b[SHAMT_W-1:0]),
    .left_i   (left_c),
    .arith_i  (arith_c),
    .done_c   (eng_done_c),
    .result_c (eng_res_c)
  );

  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    zero_d      = zero_q;
    illegal_d   = illegal_q;
    valid_d     = valid_q;
    eng_start_c = 1'b0;
    load_c      = 1'b0;

    case (state_q)
      ST_IDLE: load_c = accept_c;
      ST_SHIFT: begin
        if (eng_done_c) begin
          result_d = eng_res_c;
          zero_d   = (eng_res_c == '0);
          valid_d  = 1'b1;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
          load_c  = accept_c;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A new op either starts the shifter or lands directly in the output registers.
    if (load_c) begin
      illegal_d = is_illegal(bus.alu_ctrl);
      if (shift_go_c) begin
        eng_start_c = 1'b1;
        valid_d     = 1'b0;
        state_d     = ST_SHIFT;
      end else begin
        result_d = alu_res_c;
        zero_d   = (alu_res_c == '0);
        valid_d  = 1'b1;
        state_d  = ST_DONE;
      end
    end

    if (flush) begin
      state_d     = ST_IDLE;
      valid_d     = 1'b0;
      eng_start_c = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
      valid_q   <= valid_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.illegal   = illegal_q;
  assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: directed corner cases plus random ops against a reference model.
module tb_alu_exec_unit;
  import rv_alu_pkg::*;

  localparam int unsigned XLEN = 32;

  typedef struct {
    logic [31:0] res;
    logic        zero;
    logic        ill;
    int          vcyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic flush  = 1'b0;
  logic flush4 = 1'b0;
  int   cyc    = 0;
  int   n_cmp  = 0;
  int   n_err  = 0;
  int   rdy_mode = 0;
  bit   seen_rise = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_exec_unit_if #(.XLEN(XLEN)) bus ();
  alu_exec_unit_if #(.XLEN(XLEN)) bus4 ();

  alu_exec_unit #(.XLEN(XLEN), .SHIFT_STEP(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus.slave)
  );
  alu_exec_unit #(.XLEN(XLEN), .SHIFT_STEP(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .flush(flush4), .bus(bus4.slave)
  );

  // Reference behaviour straight from the op definitions.
  function automatic logic [31:0] ref_result(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
    int unsigned s;
    s = int'(b[4:0]);
    case (c)
      5'd1, 5'd2:   return a + b;
      5'd3, 5'd4:   return a | b;
      5'd5, 5'd6:   return a ^ b;
      5'd7, 5'd8:   return a & b;
      5'd9:         return a - b;
      5'd10, 5'd11: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      5'd12, 5'd13: return (a < b) ? 32'd1 : 32'd0;
      5'd14, 5'd17: return a << s;
      5'd15, 5'd18: return a >> s;
      5'd16, 5'd19: return 32'($signed(a) >>> s);
      default:      return 32'd0;
    endcase
  endfunction

  function automatic int ref_latency(input logic [4:0] c, input logic [31:0] b, input int step);
    int s;
    s = int'(b[4:0]);
    if (c >= 5'd14 && c <= 5'd19 && s != 0) return (s + step - 1) / step + 1;
    return 1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Sole driver of out_ready: 0 = always ready, 1 = random, 2 = stalled.
  initial forever begin
    case (rdy_mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = ($urandom_range(0, 3) != 0);
      default: bus.out_ready = 1'b0;
    endcase
    @(posedge clk);
    #1;
  end

  // Issue one op; the expected response is queued on the cycle it is accepted.
  task automatic issue(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b, output int waits);
    bit   done;
    exp_t e;
    done  = 0;
    waits = 0;
    bus.in_valid = 1'b1;
    bus.alu_ctrl = c;
    bus.op_a     = a;
    bus.op_b     = b;
    while (!done) begin
      @(negedge clk);
      if (bus.in_ready && !flush && rst_n) begin
        e.res  = ref_result(c, a, b);
        e.zero = (e.res == 32'd0);
        e.ill  = (c == 5'd0) || (c > 5'd19);
        e.vcyc = cyc + ref_latency(c, b, 1);
        sb.push_back(e);
        done = 1;
      end else begin
        waits++;
        if (waits > 400) begin
          chk("accept_timeout", 32'd0, 32'd1);
          done = 1;
        end
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 300) begin
      tick(1);
      k++;
    end
    chk("drain_pending", 32'(sb.size()), 32'd0);
    tick(1);
  endtask

  // Directed run on the SHIFT_STEP=4 instance, measuring latency in cycles.
  task automatic run4(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
    int k;
    k = 0;
    bus4.in_valid = 1'b1;
    bus4.alu_ctrl = c;
    bus4.op_a     = a;
    bus4.op_b     = b;
    @(negedge clk);
    chk("s4_in_ready", 32'(bus4.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus4.in_valid = 1'b0;
    while (!bus4.out_valid && k < 50) begin
      tick(1);
      k++;
    end
    chk("s4_latency", 32'(k + 1), 32'(ref_latency(c, b, 4)));
    chk("s4_result", bus4.result, ref_result(c, a, b));
    tick(1);
  endtask

  // Monitor: compares on every output handshake and checks when out_valid first rises.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      seen_rise = 0;
    end else begin
      if (bus.out_valid) begin
        if (sb.size() == 0) begin
          chk("spurious_out_valid", 32'd1, 32'd0);
        end else begin
          if (!seen_rise) begin
            chk("latency", 32'(cyc), 32'(sb[0].vcyc));
            seen_rise = 1;
          end
          if (bus.out_ready) begin
            e = sb.pop_front();
            chk("result", bus.result, e.res);
            chk("zero", 32'(bus.zero), 32'(e.zero));
            chk("illegal", 32'(bus.illegal), 32'(e.ill));
            seen_rise = 0;
          end
        end
      end
      if (flush) begin
        sb.delete();
        seen_rise = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int          w;
    logic [4:0]  c;
    logic [31:0] a, b, held;

    bus.in_valid  = 1'b0;
    bus.alu_ctrl  = '0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus4.in_valid = 1'b0;
    bus4.alu_ctrl = '0;
    bus4.op_a     = '0;
    bus4.op_b     = '0;
    bus4.out_ready = 1'b1;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #2;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_result", bus.result, 32'd0);
    chk("rst_zero", 32'(bus.zero), 32'd0);
    chk("rst_illegal", 32'(bus.illegal), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    tick(2);
    rst_n = 1'b1;
    tick(1);

    // Wrap-around add giving zero.
    issue(5'd1, 32'hFFFF_FFFF, 32'h1, w);
    wait_drain();

    // Back-to-back single-cycle ops with no gap in acceptance.
    issue(5'd9, 32'd5, 32'd7, w);
    chk("b2b_wait_sub", 32'(w), 32'd0);
    issue(5'd10, 32'hFFFF_FFFE, 32'd1, w);
    chk("b2b_wait_slt", 32'(w), 32'd0);
    issue(5'd12, 32'hFFFF_FFFE, 32'd1, w);
    chk("b2b_wait_sltu", 32'(w), 32'd0);
    wait_drain();

    // Long arithmetic shift: unit is unavailable while shifting.
    issue(5'd19, 32'h8000_0000, 32'd31, w);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("shift_in_ready", 32'(bus.in_ready), 32'd0);
      chk("shift_busy", 32'(bus.busy), 32'd1);
    end
    @(posedge clk);
    #1;
    wait_drain();

    // Zero-distance and short left shifts.
    issue(5'd17, 32'h1, 32'd0, w);
    issue(5'd17, 32'h1, 32'd5, w);
    wait_drain();

    run4(5'd17, 32'h1, 32'd5);
    run4(5'd19, 32'h8000_0000, 32'd31);
    run4(5'd15, 32'hDEAD_BEEF, 32'd0);

    // Stalled result holds while a new request is refused.
    rdy_mode = 2;
    tick(1);
    issue(5'd1, 32'h1234, 32'h1111, w);
    held = ref_result(5'd1, 32'h1234, 32'h1111);
    bus.in_valid = 1'b1;
    bus.alu_ctrl = 5'd9;
    bus.op_a     = 32'h55;
    bus.op_b     = 32'h11;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_result", bus.result, held);
      chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
      chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    rdy_mode = 0;
    issue(5'd25, 32'hABCD, 32'h1, w);
    wait_drain();

    // Flush mid-shift discards the op; the next op is unaffected.
    issue(5'd18, 32'hF000_0000, 32'd20, w);
    tick(5);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    chk("flush_busy", 32'(bus.busy), 32'd0);
    issue(5'd1, 32'd100, 32'd23, w);
    wait_drain();

    // Random traffic with random backpressure.
    rdy_mode = 1;
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        c = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom_range(20, 31));
      end else begin
        c = 5'($urandom_range(1, 19));
      end
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      issue(c, a, b, w);
      if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 3));
    end
    rdy_mode = 0;
    wait_drain();

    // Asynchronous reset in the middle of a shift.
    issue(5'd1, 32'd0, 32'd0, w);
    wait_drain();
    issue(5'd19, 32'h8000_0000, 32'd31, w);
    tick(6);
    #2 rst_n = 1'b0;
    #1;
    sb.delete();
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_result", bus.result, 32'd0);
    chk("mid_rst_zero", 32'(bus.zero), 32'd0);
    chk("mid_rst_illegal", 32'(bus.illegal), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 35; i++) begin
      @(negedge clk);
      chk("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    issue(5'd1, 32'd3, 32'd4, w);
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
